// File: rtl/fifo_stream_arbiter.sv
// fifo_stream_arbiter
//   Round-robin merge of NUM_SRC first-word-fall-through 32-bit streams into
//   one registered 32-bit stream feeding the SRAM FIFO core.
//
// Ports
//   BUS_CLK, BUS_RST        : clock, synchronous active-high reset
//   BUS_ADD/DATA_IN/RD/WR   : register bus (0 VERSION / soft reset, 1 EN_MASK,
//                             2 MAX_BURST, 3..6 WORD_CNT bytes)
//   BUS_DATA_OUT            : registered read data, one cycle latency
//   SRC_EMPTY/SRC_DATA      : per-source FWFT streams, source i at [32i+31:32i]
//   SRC_READ                : per-source pop strobe
//   FIFO_READ_NEXT_IN       : downstream accepts FIFO_DATA_OUT
//   FIFO_EMPTY_OUT/DATA_OUT : merged output stream
module fifo_stream_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter logic [7:0]  VERSION = 8'd1
) (
  input  logic                   BUS_CLK,
  input  logic                   BUS_RST,
  input  logic [15:0]            BUS_ADD,
  input  logic [7:0]             BUS_DATA_IN,
  input  logic                   BUS_RD,
  input  logic                   BUS_WR,
  output logic [7:0]             BUS_DATA_OUT,
  input  logic [NUM_SRC-1:0]     SRC_EMPTY,
  input  logic [32*NUM_SRC-1:0]  SRC_DATA,
  output logic [NUM_SRC-1:0]     SRC_READ,
  input  logic                   FIFO_READ_NEXT_IN,
  output logic                   FIFO_EMPTY_OUT,
  output logic [31:0]            FIFO_DATA_OUT
);

  localparam int unsigned GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [7:0]    en_mask_q, en_mask_d;
  logic [7:0]    max_burst_q, max_burst_d;
  logic [31:0]   word_cnt_q, word_cnt_d;
  logic [23:0]   cnt_buf_q, cnt_buf_d;
  logic [7:0]    bus_data_q, bus_data_d;

  logic               rst;
  logic [NUM_SRC-1:0] req;
  logic               req_grant;
  logic [31:0]        grant_data;
  logic               can_load;
  logic               pop;
  logic               out_xfer;
  logic               rr_found;
  logic [GW-1:0]      rr_pick;
  logic [GW-1:0]      cand;

  assign rst      = BUS_RST | (BUS_WR && (BUS_ADD == 16'd0));
  assign req      = ~SRC_EMPTY & en_mask_q[NUM_SRC-1:0];
  assign can_load = !out_valid_q || FIFO_READ_NEXT_IN;
  assign out_xfer = out_valid_q && FIFO_READ_NEXT_IN;

  // Pop is masked by reset so no source word is consumed and then lost.
  assign pop = !rst && (state_q == BURST) && req_grant && can_load;

  assign FIFO_EMPTY_OUT = !out_valid_q;
  assign FIFO_DATA_OUT  = out_data_q;
  assign BUS_DATA_OUT   = bus_data_q;

  // Granted-source request and data select.
  always_comb begin
    req_grant  = 1'b0;
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == GW'(i)) begin
        req_grant  = req[i];
        grant_data = SRC_DATA[32*i +: 32];
      end
    end
  end

  always_comb begin
    SRC_READ = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pop && (grant_q == GW'(i))) SRC_READ[i] = 1'b1;
    end
  end

  // Rotating priority: first requester after last, wrapping through last itself.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_q;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = GW'((32'(last_q) + k) % NUM_SRC);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    en_mask_d   = en_mask_q;
    max_burst_d = max_burst_q;
    word_cnt_d  = word_cnt_q;
    cnt_buf_d   = cnt_buf_q;
    bus_data_d  = bus_data_q;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d     = rr_pick;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (!req_grant) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (pop) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if ((max_burst_q != 8'd0) && (burst_cnt_q == max_burst_q - 8'd1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      out_data_d  = grant_data;
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    if (out_xfer) word_cnt_d = word_cnt_q + 32'd1;

    if (BUS_WR) begin
      case (BUS_ADD)
        16'd1:   en_mask_d   = BUS_DATA_IN;
        16'd2:   max_burst_d = BUS_DATA_IN;
        default: ;
      endcase
    end

    // Reading the low byte snapshots the upper bytes so a multi-read is coherent.
    if (BUS_RD) begin
      case (BUS_ADD)
        16'd0: bus_data_d = VERSION;
        16'd1: bus_data_d = en_mask_q;
        16'd2: bus_data_d = max_burst_q;
        16'd3: begin
          bus_data_d = word_cnt_q[7:0];
          cnt_buf_d  = word_cnt_q[31:8];
        end
        16'd4:   bus_data_d = cnt_buf_q[7:0];
        16'd5:   bus_data_d = cnt_buf_q[15:8];
        16'd6:   bus_data_d = cnt_buf_q[23:16];
        default: bus_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NUM_SRC - 1);
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      en_mask_q   <= '1;
      max_burst_q <= 8'd16;
      word_cnt_q  <= '0;
      cnt_buf_q   <= '0;
      bus_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      en_mask_q   <= en_mask_d;
      max_burst_q <= max_burst_d;
      word_cnt_q  <= word_cnt_d;
      cnt_buf_q   <= cnt_buf_d;
      bus_data_q  <= bus_data_d;
    end
  end

endmodule

// File: doc/fifo_stream_arbiter.md
# fifo_stream_arbiter

Round-robin arbiter that merges up to `NUM_SRC` 32-bit first-word-fall-through readout streams into the single 32-bit stream consumed by the SRAM FIFO core (`FIFO_DATA` / `FIFO_EMPTY_IN` / `FIFO_READ_NEXT_OUT`). It sits directly upstream of that core, between the per-channel receivers/TDCs and the SRAM buffer. It has a bus-configurable enable mask and burst limit, and keeps a transferred-word counter.

## Interface
- `NUM_SRC`, 4: number of source streams (2..8).
- `VERSION`, 1: value returned on bus read of address 0.
- `BUS_CLK` in 1: the single clock for all logic.
- `BUS_RST` in 1: synchronous, active-high reset.
- `BUS_ADD` in 16: register address.
- `BUS_DATA_IN` in 8: write data.
- `BUS_RD` in 1: read strobe.
- `BUS_WR` in 1: write strobe.
- `BUS_DATA_OUT` out 8: registered read data.
- `SRC_EMPTY` in NUM_SRC: per-source empty flag; low means `SRC_DATA` is valid.
- `SRC_DATA` in 32*NUM_SRC: source i occupies bits [32i+31:32i].
- `SRC_READ` out NUM_SRC: pop strobe, one bit per source.
- `FIFO_READ_NEXT_IN` in 1: downstream accepts the current word.
- `FIFO_EMPTY_OUT` out 1: low means `FIFO_DATA_OUT` is valid.
- `FIFO_DATA_OUT` out 32: output word.

## Operation
- Handshakes:
  - An input transfer happens when `SRC_EMPTY[i]`=0 and `SRC_READ[i]`=1.
  - An output transfer happens when `FIFO_EMPTY_OUT`=0 and `FIFO_READ_NEXT_IN`=1.
- Soft reset: a bus write to address 0. `RST = BUS_RST | soft reset`, and it clears everything below.
- Registers:
  - Address 0: read returns `VERSION`.
  - Address 1: `EN_MASK`, reset value all ones. Bits at and above `NUM_SRC` are ignored.
  - Address 2: `MAX_BURST`, reset value 16. A value of 0 means unlimited.
  - Addresses 3-6: `WORD_CNT`, 32 bits, read-only. A read of address 3 returns bits [7:0] and latches [31:8] into a buffer. Reads of 4, 5, 6 return buffer bytes [15:8], [23:16], [31:24].
  - Any other address reads 0.
- Request: `req[i] = !SRC_EMPTY[i] && EN_MASK[i]`.
- State machine, states IDLE and BURST:
  - IDLE: if any `req` is set, `grant` becomes the first requesting index searching from `last+1` modulo `NUM_SRC`. `burst_cnt` is cleared and the state moves to BURST. Arbitration costs one cycle, and nothing is popped in IDLE.
  - BURST: `can_load = !out_valid || FIFO_READ_NEXT_IN`. `pop = req[grant] && can_load`. `SRC_READ[grant] = pop`; all other `SRC_READ` bits are 0.
  - BURST, on pop: `burst_cnt` increments.
  - BURST exit: the state returns to IDLE and `last` takes the value of `grant` when either `req[grant]`=0, or a pop occurs with `MAX_BURST`≠0 and `burst_cnt == MAX_BURST-1`.
- Output register:
  - On pop, `out_data` loads `SRC_DATA[grant]` and `out_valid` is set to 1.
  - On an output transfer with no pop, `out_valid` is cleared to 0.
  - `FIFO_EMPTY_OUT = !out_valid`; `FIFO_DATA_OUT = out_data`.
- `WORD_CNT` increments by 1 on every output transfer and wraps at 2^32.
- Words are never duplicated or dropped. Per-source order is preserved.

## Timing
- Reset values: `SRC_READ`=0; `FIFO_EMPTY_OUT`=1; `FIFO_DATA_OUT`=0; `BUS_DATA_OUT`=0; state IDLE; `last = NUM_SRC-1`, so source 0 wins first; `WORD_CNT`=0.
- Latency: a source goes non-empty before edge t while in IDLE → grant at edge t → `SRC_READ` high during cycle t..t+1 → `FIFO_EMPTY_OUT` low after edge t+1.
- Throughput: with the output continuously read, one word per cycle within a burst, plus one idle cycle per grant change.
- Output stall: `FIFO_READ_NEXT_IN`=0 while `out_valid`=1 gives `pop`=0. `FIFO_DATA_OUT` is held stable, and `burst_cnt` and `grant` are frozen.
- Source empties mid-burst, or its `EN_MASK` bit is cleared mid-burst: no pop that cycle, return to IDLE, and rotation continues from that source.
- `MAX_BURST`=1: strict word-by-word round robin, two cycles per word.
- Register writes take effect the cycle after the write edge.
- Bus reads are registered with one-cycle latency.
- Reset asserted mid-operation: `SRC_READ` is 0 during every reset cycle. Any word held in the output register is discarded, and `FIFO_EMPTY_OUT`=1 at the first edge in reset.

## Test plan
- Reset, then sources 0 and 2 each preload 3 words, output always ready, `MAX_BURST`=16:
  - Output is s0w0..s0w2, then s2w0..s2w2.
  - First `FIFO_EMPTY_OUT`=0 is two edges after reset release.
  - `WORD_CNT`=6.
- `MAX_BURST`=2, all 4 sources full with 4 words each:
  - Output order is s0,s0,s1,s1,s2,s2,s3,s3,s0,s0,...
  - Exactly one idle cycle between pairs.
- `FIFO_READ_NEXT_IN` low for 5 cycles mid-burst:
  - `FIFO_DATA_OUT` is constant and `SRC_READ`=0 throughout.
  - No loss or duplication after the stall is released.
- Write `EN_MASK`=0x5 while source 1 is in a burst:
  - Source 1 is not popped from the next cycle on.
  - Only sources 0 and 2 continue.
- 300 transfers, then read addresses 3, 4, 5, 6:
  - Returns 0x2C, 0x01, 0x00, 0x00.
  - A write to address 0 then reads back `WORD_CNT`=0 with `FIFO_EMPTY_OUT`=1.
- Assert `BUS_RST` for 1 cycle with a word in the output register:
  - Word discarded and `FIFO_EMPTY_OUT`=1.
  - Arbitration restarts at source 0.
